// File: rtl/elevator_request_scheduler_pkg.sv
// Shared constants and the scheduler state type for the elevator request scheduler.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS         = 11;
  localparam int unsigned FLOOR_W            = 4;
  localparam int unsigned TRAVEL_TIMEOUT_DEF = 4096;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    DISPATCH,
    TRAVEL,
    SERVICE,
    HALT
  } sched_state_t;

endpackage

// File: rtl/elevator_request_scheduler_if.sv
// Button, car-position and dispatch signals between the scheduler, the debouncers and the motion FSM.
interface elevator_request_scheduler_if #(
  parameter int unsigned NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int unsigned FLOOR_W    = elevator_pkg::FLOOR_W
);

  logic [NUM_FLOORS-1:0] hall_call_pulse;
  logic [NUM_FLOORS-1:0] car_call_pulse;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  at_floor;
  logic                  dispatch_ready;
  logic                  service_done;
  logic                  emergency;
  logic                  power_on;
  logic                  target_valid;
  logic [FLOOR_W-1:0]    target_floor;
  logic                  target_up;
  logic [NUM_FLOORS-1:0] hall_call_lights;
  logic [NUM_FLOORS-1:0] car_call_lights;
  logic                  sched_busy;
  logic                  fault;

  modport master (
    input  hall_call_pulse, car_call_pulse, current_floor, at_floor,
           dispatch_ready, service_done, emergency, power_on,
    output target_valid, target_floor, target_up, hall_call_lights,
           car_call_lights, sched_busy, fault
  );

  modport slave (
    output hall_call_pulse, car_call_pulse, current_floor, at_floor,
           dispatch_ready, service_done, emergency, power_on,
    input  target_valid, target_floor, target_up, hall_call_lights,
           car_call_lights, sched_busy, fault
  );

endinterface

// File: rtl/elevator_request_scheduler_picker.sv
// Combinational LOOK helper: nearest pending floor above/below the car and the direction to take.
module floor_request_picker #(
  parameter int unsigned NUM_FLOORS = 11,
  parameter int unsigned FLOOR_W    = 4
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  dir_up,
  output logic                  found_above,
  output logic [FLOOR_W-1:0]    nearest_above,
  output logic                  found_below,
  output logic [FLOOR_W-1:0]    nearest_below,
  output logic                  here,
  output logic                  go_up,
  output logic                  go_down
);

  // Ascending scan: first hit above is the lowest, last hit below is the highest.
  always_comb begin
    found_above   = 1'b0;
    nearest_above = '0;
    found_below   = 1'b0;
    nearest_below = '0;
    here          = 1'b0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (pending[i]) begin
        if (FLOOR_W'(i) > current_floor) begin
          if (!found_above) begin
            found_above   = 1'b1;
            nearest_above = FLOOR_W'(i);
          end
        end else if (FLOOR_W'(i) < current_floor) begin
          found_below   = 1'b1;
          nearest_below = FLOOR_W'(i);
        end else begin
          here = 1'b1;
        end
      end
    end
  end

  // Keep the current sweep direction; reverse only when nothing remains ahead.
  always_comb begin
    go_up   = found_above && (dir_up || !found_below);
    go_down = found_below && (!dir_up || !found_above);
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// LOOK request scheduler: latches calls, selects the next floor and hands it to the motion FSM.
module elevator_request_scheduler #(
  parameter int unsigned NUM_FLOORS     = elevator_pkg::NUM_FLOORS,
  parameter int unsigned FLOOR_W        = elevator_pkg::FLOOR_W,
  parameter int unsigned TRAVEL_TIMEOUT = elevator_pkg::TRAVEL_TIMEOUT_DEF
) (
  input logic                          clock,
  input logic                          reset,
  elevator_request_scheduler_if.master bus
);

  import elevator_pkg::*;

  localparam int unsigned TMR_W = $clog2(TRAVEL_TIMEOUT + 1);

  sched_state_t          r_state;
  logic                  r_dir_up;
  logic [NUM_FLOORS-1:0] r_hall_req;
  logic [NUM_FLOORS-1:0] r_car_req;
  logic                  r_target_valid;
  logic [FLOOR_W-1:0]    r_target_floor;
  logic                  r_target_up;
  logic                  r_busy;
  logic                  r_fault;
  logic [TMR_W-1:0]      r_timer;

  logic [NUM_FLOORS-1:0] w_pending;
  logic [NUM_FLOORS-1:0] w_clr;
  logic [NUM_FLOORS-1:0] w_hall_next;
  logic [NUM_FLOORS-1:0] w_car_next;
  logic                  w_pending_next_any;
  logic                  w_halt_req;
  logic                  w_found_above;
  logic                  w_found_below;
  logic                  w_here;
  logic                  w_any;
  logic                  w_go_up;
  logic                  w_go_down;
  logic [FLOOR_W-1:0]    w_nearest_above;
  logic [FLOOR_W-1:0]    w_nearest_below;

  // Clear beats a same-cycle set; losing power drops every car call, pulses included.
  always_comb begin
    w_clr              = bus.service_done ? (NUM_FLOORS'(1) << r_target_floor) : '0;
    w_hall_next        = (r_hall_req | bus.hall_call_pulse) & ~w_clr;
    w_car_next         = bus.power_on ? ((r_car_req | bus.car_call_pulse) & ~w_clr) : '0;
    w_pending          = r_hall_req | r_car_req;
    w_pending_next_any = |(w_hall_next | w_car_next);
    w_halt_req         = bus.emergency || !bus.power_on;
    w_any              = w_found_above || w_found_below || w_here;
  end

  floor_request_picker #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_picker (
    .pending       (w_pending),
    .current_floor (bus.current_floor),
    .dir_up        (r_dir_up),
    .found_above   (w_found_above),
    .nearest_above (w_nearest_above),
    .found_below   (w_found_below),
    .nearest_below (w_nearest_below),
    .here          (w_here),
    .go_up         (w_go_up),
    .go_down       (w_go_down)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hall_req <= '0;
      r_car_req  <= '0;
    end else begin
      r_hall_req <= w_hall_next;
      r_car_req  <= w_car_next;
    end
  end

  // Scheduler FSM; emergency or power loss overrides every state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_dir_up       <= 1'b1;
      r_target_valid <= 1'b0;
      r_target_floor <= '0;
      r_target_up    <= 1'b1;
      r_busy         <= 1'b0;
      r_fault        <= 1'b0;
      r_timer        <= '0;
    end else if (w_halt_req) begin
      r_state        <= HALT;
      r_target_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pending != '0) begin
            r_state <= SELECT;
            r_busy  <= 1'b1;
          end
        end
        SELECT: begin
          if (!w_any) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state        <= DISPATCH;
            r_target_valid <= 1'b1;
            if (w_go_up) begin
              r_target_floor <= w_nearest_above;
              r_dir_up       <= 1'b1;
              r_target_up    <= 1'b1;
            end else if (w_go_down) begin
              r_target_floor <= w_nearest_below;
              r_dir_up       <= 1'b0;
              r_target_up    <= 1'b0;
            end else begin
              r_target_floor <= bus.current_floor;
              r_target_up    <= 1'b1;
            end
          end
        end
        DISPATCH: begin
          if (r_target_valid && bus.dispatch_ready) begin
            r_state        <= TRAVEL;
            r_target_valid <= 1'b0;
            r_timer        <= '0;
          end
        end
        TRAVEL: begin
          if (bus.at_floor && (bus.current_floor == r_target_floor)) begin
            r_state <= SERVICE;
          end else if (r_timer == TMR_W'(TRAVEL_TIMEOUT - 1)) begin
            r_state <= HALT;
            r_fault <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        SERVICE: begin
          if (bus.service_done) begin
            if (w_pending_next_any) begin
              r_state <= SELECT;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        HALT: begin
          // A timeout fault latches the car here until reset.
          if (!r_fault) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.target_valid     = r_target_valid;
  assign bus.target_floor     = r_target_floor;
  assign bus.target_up        = r_target_up;
  assign bus.hall_call_lights = r_hall_req;
  assign bus.car_call_lights  = r_car_req;
  assign bus.sched_busy       = r_busy;
  assign bus.fault            = r_fault;

endmodule
